// File: rtl/inst_sram_like_bridge.sv
// Bridges the core's SRAM-style instruction fetch port onto the sram-like
// req/addr_ok/data_ok bus, with at most one outstanding read.
module inst_sram_like_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_sram_en,
   input  logic [ADDR_W-1:0] inst_sram_addr,
   output logic [DATA_W-1:0] inst_sram_rdata,
   output logic              i_stall,
   input  logic              longest_stall,
   input  logic              cancel,
   output logic              inst_req,
   output logic              inst_wr,
   output logic [1:0]        inst_size,
   output logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_wdata,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [DATA_W-1:0] inst_rdata
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      DONE      = 2'd2,
      DROP      = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              req;

   // Outputs are forced low while reset is held, even though en may be high.
   assign req             = rst & inst_sram_en & (state_q == IDLE) & ~cancel;
   assign inst_req        = req;
   assign i_stall         = rst & ((inst_sram_en & (state_q != DONE)) | (state_q == DROP));
   assign inst_sram_rdata = buf_q;
   assign inst_addr       = inst_sram_addr;
   assign inst_wr         = 1'b0;
   assign inst_size       = 2'b10;
   assign inst_wdata      = '0;

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      case (state_q)
         IDLE: begin
            if (req && inst_addr_ok) begin
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (inst_data_ok && !cancel) begin
               state_d = DONE;
               buf_d   = inst_rdata;
            end else if (cancel && !inst_data_ok) begin
               state_d = DROP;
            end else if (cancel && inst_data_ok) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            // A flush releases the buffered word even if the pipeline is held.
            if (cancel || !longest_stall) begin
               state_d = IDLE;
            end
         end
         DROP: begin
            if (inst_data_ok) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
      end
   end

endmodule

// File: tb/tb_inst_sram_like_bridge.sv
// Directed and randomized checks of inst_sram_like_bridge against a
// transaction-level model (pending / squashed / held word).
module tb_inst_sram_like_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, ls, cancel, aok, dok;
   logic [31:0] addr, rdata_in;
   logic [31:0] sram_rdata, bus_addr, bus_wdata;
   logic        stall, req, wr;
   logic [1:0]  size;

   int checks   = 0;
   int failures = 0;

   // Model: a read is pending on the bus, it may be squashed, or a word is held.
   bit          m_pend, m_sq, m_held;
   logic [31:0] m_buf;

   inst_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_sram_en(en), .inst_sram_addr(addr), .inst_sram_rdata(sram_rdata),
      .i_stall(stall), .longest_stall(ls), .cancel(cancel),
      .inst_req(req), .inst_wr(wr), .inst_size(size), .inst_addr(bus_addr),
      .inst_wdata(bus_wdata), .inst_addr_ok(aok), .inst_data_ok(dok),
      .inst_rdata(rdata_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_req();
      return rst & en & !m_pend & !m_held & !cancel;
   endfunction

   function automatic logic exp_stall();
      return rst & ((en & !m_held) | (m_pend & m_sq));
   endfunction

   task automatic model_reset();
      m_pend = 0; m_sq = 0; m_held = 0; m_buf = 32'h0;
   endtask

   task automatic model_step();
      if (!rst) model_reset();
      else if (m_held) begin
         if (cancel || !ls) m_held = 0;
      end else if (m_pend) begin
         if (dok) begin
            m_pend = 0;
            if (!m_sq && !cancel) begin
               m_held = 1;
               m_buf  = rdata_in;
            end
            m_sq = 0;
         end else if (cancel) m_sq = 1;
      end else if (en && !cancel && aok) m_pend = 1;
   endtask

   task automatic drv(input logic e, input logic ao, input logic dk, input logic cn, input logic l);
      en = e; aok = ao; dok = dk; cancel = cn; ls = l;
   endtask

   // One clock: compare against the model at the falling edge, advance at the rising edge.
   task automatic tick();
      @(negedge clk);
      chk("req", req, exp_req());
      chk("i_stall", stall, exp_stall());
      chk("rdata", sram_rdata, m_buf);
      chk("inst_addr", bus_addr, addr);
      chk("const_wr_size", {29'd0, wr, size}, 32'd2);
      chk("const_wdata", bus_wdata, 32'h0);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic expect_now(input string tag, input logic r, input logic s, input logic [31:0] rd);
      #2;
      chk({tag, "_req"}, req, r);
      chk({tag, "_stall"}, stall, s);
      chk({tag, "_rdata"}, sram_rdata, rd);
   endtask

   initial begin
      int stall_cnt;
      rst = 1'b0; addr = 32'hBFC0_0000; rdata_in = 32'h0;
      drv(1, 1, 0, 0, 1);
      model_reset();
      #23;
      expect_now("reset_hold", 0, 0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      expect_now("reset_release", 1, 1, 32'h0);
      drv(0, 0, 0, 0, 1);
      tick();

      // Single fetch at the reset vector
      addr = 32'hBFC0_0000;
      drv(1, 1, 0, 0, 1); expect_now("sf_c0", 1, 1, 32'h0); tick();
      drv(1, 0, 1, 0, 1); rdata_in = 32'h3C1D_8000;
      expect_now("sf_c1", 0, 1, 32'h0); tick();
      drv(1, 0, 0, 0, 1); rdata_in = 32'h0;
      expect_now("sf_c2", 0, 0, 32'h3C1D_8000); tick();
      drv(1, 0, 0, 0, 0); addr = 32'hBFC0_0004;
      expect_now("sf_c3", 0, 0, 32'h3C1D_8000); tick();
      expect_now("sf_c4", 1, 1, 32'h3C1D_8000);
      drv(0, 0, 0, 0, 0); tick();

      // Slow bus: addr_ok after 3 cycles, data_ok 4 cycles later
      stall_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         drv(1, c == 3, c == 7, 0, 1);
         rdata_in = (c == 7) ? 32'h8FBF_0010 : 32'h5555_AAAA;
         #2;
         if (stall) stall_cnt++;
         if (c < 4) chk("slow_req_held", req, 1'b1);
         tick();
      end
      chk("slow_stall_cycles", stall_cnt, 8);
      drv(1, 0, 0, 0, 1);
      expect_now("slow_done", 0, 0, 32'h8FBF_0010); tick();
      drv(0, 0, 0, 0, 0); tick();

      // Cancel in flight: stale data must not reach the buffer
      drv(1, 1, 0, 0, 1); tick();
      drv(1, 0, 0, 1, 1); tick();
      addr = 32'hBFC0_0380;
      drv(1, 0, 0, 0, 1); expect_now("drop_wait", 0, 1, 32'h8FBF_0010); tick();
      drv(1, 0, 1, 0, 1); rdata_in = 32'hDEAD_BEEF;
      expect_now("drop_dok", 0, 1, 32'h8FBF_0010); tick();
      drv(1, 1, 0, 0, 1); expect_now("drop_refetch", 1, 1, 32'h8FBF_0010); tick();
      drv(1, 0, 1, 0, 1); rdata_in = 32'h1111_1111; tick();
      drv(1, 0, 0, 0, 0); expect_now("redirect_word", 0, 0, 32'h1111_1111); tick();
      drv(0, 0, 0, 0, 0); tick();

      // Cancel and data_ok in the same WAIT_DATA cycle
      drv(1, 1, 0, 0, 1); tick();
      drv(1, 0, 1, 1, 1); rdata_in = 32'hBAD0_BAD0; tick();
      drv(1, 0, 0, 0, 1); expect_now("cancel_dok_idle", 1, 1, 32'h1111_1111);
      drv(0, 0, 0, 0, 1); tick();

      // Held pipeline with spurious data_ok while DONE
      drv(1, 1, 0, 0, 1); tick();
      drv(1, 0, 1, 0, 1); rdata_in = 32'h2408_0001; tick();
      for (int c = 0; c < 5; c++) begin
         drv(1, c[0], c[0] == 1'b0, 0, 1); rdata_in = 32'hFFFF_FFFF;
         expect_now("held", 0, 0, 32'h2408_0001); tick();
      end
      drv(1, 0, 1, 0, 0); expect_now("held_exit", 0, 0, 32'h2408_0001); tick();
      drv(1, 0, 0, 0, 1); expect_now("held_idle", 1, 1, 32'h2408_0001);
      drv(0, 0, 0, 0, 1); tick();

      // Reset in the middle of a transaction
      drv(1, 1, 0, 0, 1); tick();
      drv(1, 0, 0, 0, 1);
      rst = 1'b0; model_reset();
      expect_now("midreset", 0, 0, 32'h0);
      drv(1, 0, 1, 0, 1); rdata_in = 32'h7777_7777; tick();
      rst = 1'b1;
      expect_now("after_midreset", 1, 1, 32'h0);
      drv(0, 0, 1, 0, 1); tick();

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         en     = ($urandom_range(0, 3) != 0);
         cancel = ($urandom_range(0, 9) == 0);
         ls     = $urandom_range(0, 1);
         aok    = $urandom_range(0, 1);
         dok    = $urandom_range(0, 1);
         rdata_in = $urandom;
         if (!exp_stall() && !m_held) addr = $urandom & 32'hFFFF_FFFC;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
